step_pulse_gen: RTL
===================

// Module: step_pulse_gen
// PURPOSE
//  Upstream front end for the 8-bit load/rotate register on the DE board. Debounces the
//  active-low pushbutton, emits exactly one single-cycle step per clean press, and
//  presents synchronized switch controls that are stable whenever step is high.
//  The downstream register advances only on clk edges where step=1, never on a raw key edge.
// PARAMETERS
//  CLK_HZ          50_000_000  system clock frequency in Hz
//  DEBOUNCE_MS     10          stable time required before a press/release is accepted
//  DATA_W          8           width of parallel-load data
//  REPEAT_DELAY_MS 500         hold time before the first auto-repeat step (macro only)
//  REPEAT_RATE_MS  100         period of later auto-repeat steps (macro only)
// PORTS
//  clk       in   1       system clock (CLOCK_50)
//  resetn    in   1       asynchronous active-low reset
//  key_n     in   1       raw pushbutton, 0 = pressed, asynchronous
//  sw_load   in   1       raw switch: 1 = parallel load, 0 = rotate
//  sw_dir    in   1       raw switch: 1 = rotate right, 0 = rotate left
//  sw_data   in   DATA_W  raw switch load value
//  step      out  1       one-cycle advance strobe
//  par_load  out  1       registered load select, valid while step=1
//  rot_right out  1       registered direction, valid while step=1
//  load_data out  DATA_W  registered load value, valid while step=1
//  busy      out  1       1 while FSM is not IDLE
// BEHAVIOUR
//  - key_n, sw_load and sw_dir each pass through a 2-FF synchronizer. sw_data goes through
//    the same 2-FF chain per bit; switches are static during use.
//  - DB = CLK_HZ/1000*DEBOUNCE_MS cycles. The debounce counter is $clog2(DB+1) bits and
//    saturates at DB.
//  - FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
//    IDLE: synced key low -> PRESS_CHK, counter=0.
//    PRESS_CHK: key high -> IDLE. Key low for DB consecutive cycles -> HELD.
//    HELD: on the entry edge, step=1 for exactly one cycle. Key high -> REL_CHK, counter=0.
//    REL_CHK: key low -> HELD, with no new step. Key high for DB cycles -> IDLE.
//  - Latency: step asserts 2+DB+1 clk edges after key_n falls, given no bounce.
//  - On the edge that raises step, par_load, rot_right and load_data capture the synced
//    switch values. They hold until the next step.
//  - Reset: step=0, par_load=0, rot_right=0, load_data=0, counters=0, state=REL_CHK.
//    The key must read released for DB cycles before any press counts.
//    A key held through reset therefore produces no step.
//  - Reset asserted mid-press drops step the same cycle. No pulse is stretched or queued.
//  - step never asserts on two consecutive cycles.
// CONFIGURATION
//  STEP_AUTO_REPEAT_EN defined:
//    In HELD, a repeat counter runs. After REPEAT_DELAY cycles it emits a step, then one
//    step every REPEAT_RATE cycles. Switch values are recaptured on each step.
//    The counter clears on entry to HELD and on exit from HELD.
//    Entering REL_CHK suspends repeats; returning to HELD restarts at the delay.
//  STEP_AUTO_REPEAT_EN undefined:
//    Exactly one step per accepted press. No repeat counter is present.
// STRUCTURE
//  - Package step_gen_pkg holds:
//    - typedef enum logic [1:0] state_t {IDLE, PRESS_CHK, HELD, REL_CHK}
//    - function ms_to_cycles(hz, ms)
//  - Sub-module bit_sync: 2-FF synchronizer with async active-low reset, reset value
//    parameter RST_VAL. It is instantiated with RST_VAL=1 for key_n and RST_VAL=0 otherwise.
// TESTING (sim params CLK_HZ=1000, DEBOUNCE_MS=4 -> DB=4, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=8)
//  1. Reset with key_n=1, wait 10 cycles, then press cleanly holding sw_load=1, sw_data=8'hA5
//     -> one step exactly 7 cycles after the fall, with par_load=1 and load_data=8'hA5.
//  2. key_n toggles every 2 cycles for 20 cycles, then stays high -> zero steps;
//     busy returns to 0.
//  3. Held press with release bounce 1-0-1-0 followed by stable high -> exactly one step total.
//  4. key_n held low through reset release for 50 cycles -> no step. Release, then press
//     again -> one step.
//  5. sw_dir changes 1 cycle before step vs 5 cycles before step
//     -> rot_right reflects the synced value at the step edge, and stays constant between steps.
//  6. STEP_AUTO_REPEAT_EN defined, key held 60 cycles -> steps at press+7, +27, +35, +43, +51,
//     +59. Without the macro, the same hold gives exactly one step.

Source files
------------

// File: rtl/step_gen_pkg.sv
// ============================================================================
// step_gen_pkg : shared FSM state type and ms-to-cycle helper for step_pulse_gen
// Rev 1.0
// ============================================================================
`default_nettype none

package step_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  function automatic int ms_to_cycles(input int hz, input int ms);
    return hz / 1000 * ms;
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_pulse_gen_if.sv
// ============================================================================
// step_pulse_gen_if : raw board controls in, step strobe and captured controls out
// Rev 1.0
// ============================================================================
`default_nettype none

interface step_pulse_gen_if #(
  parameter int DATA_W = 8
);
  logic              key_n;
  logic              sw_load;
  logic              sw_dir;
  logic [DATA_W-1:0] sw_data;
  logic              step;
  logic              par_load;
  logic              rot_right;
  logic [DATA_W-1:0] load_data;
  logic              busy;

  modport master (
    input  key_n, sw_load, sw_dir, sw_data,
    output step, par_load, rot_right, load_data, busy
  );

  modport slave (
    output key_n, sw_load, sw_dir, sw_data,
    input  step, par_load, rot_right, load_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/bit_sync.sv
// ============================================================================
// bit_sync : two-flop synchronizer with async active-low reset to RST_VAL
// Rev 1.0
// ============================================================================
`default_nettype none

module bit_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

`default_nettype wire

// File: rtl/step_pulse_gen.sv
// ============================================================================
// step_pulse_gen : debounced pushbutton -> single-cycle step with captured switches
// Optional auto-repeat while held: define STEP_AUTO_REPEAT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module step_pulse_gen
  import step_gen_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_MS     = 10,
`ifdef STEP_AUTO_REPEAT_EN
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
`endif
  parameter int DATA_W          = 8
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  step_pulse_gen_if.master  bus
);
  localparam int               DB    = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int               CNT_W = $clog2(DB + 1);
  localparam logic [CNT_W-1:0] DB_C  = CNT_W'(DB);

  logic              key_s, load_s, dir_s;
  logic [DATA_W-1:0] data_s;

  bit_sync #(.RST_VAL(1'b1)) u_key_sync  (.clk(clk), .rst_n(resetn), .d(bus.key_n),   .q(key_s));
  bit_sync #(.RST_VAL(1'b0)) u_load_sync (.clk(clk), .rst_n(resetn), .d(bus.sw_load), .q(load_s));
  bit_sync #(.RST_VAL(1'b0)) u_dir_sync  (.clk(clk), .rst_n(resetn), .d(bus.sw_dir),  .q(dir_s));

  for (genvar i = 0; i < DATA_W; i++) begin : g_data_sync
    bit_sync #(.RST_VAL(1'b0)) u_sync (.clk(clk), .rst_n(resetn), .d(bus.sw_data[i]), .q(data_s[i]));
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              press_step;
  logic              step_q, step_d;
  logic              par_load_q, par_load_d;
  logic              rot_right_q, rot_right_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;

  assign cnt_inc = (cnt_q == DB_C) ? DB_C : cnt_q + CNT_W'(1);

  // Starting in REL_CHK forces a full released interval before the first press.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    press_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == DB_C) begin
          state_d    = HELD;
          cnt_d      = '0;
          press_step = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end
      end
      REL_CHK: begin
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc == DB_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = REL_CHK;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef STEP_AUTO_REPEAT_EN
  localparam int               REP_DELAY = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int               REP_RATE  = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
  localparam int               REP_W     = $clog2(REP_DELAY + 1);
  localparam logic [REP_W-1:0] REP_DELAY_C  = REP_W'(REP_DELAY);
  localparam logic [REP_W-1:0] REP_RELOAD_C = REP_W'(REP_DELAY - REP_RATE);

  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
  logic             rep_fire;

  assign rep_inc = rep_q + REP_W'(1);

  // Reloading to DELAY-RATE after each repeat spaces later steps RATE apart.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (state_q == HELD && state_d == HELD) begin
      if (rep_inc == REP_DELAY_C) begin
        rep_fire = 1'b1;
        rep_d    = REP_RELOAD_C;
      end else begin
        rep_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rep_q <= '0;
    else         rep_q <= rep_d;
  end

  always_comb step_d = press_step | rep_fire;
`else
  always_comb step_d = press_step;
`endif

  always_comb begin
    par_load_d  = par_load_q;
    rot_right_d = rot_right_q;
    load_data_d = load_data_q;
    if (step_d) begin
      par_load_d  = load_s;
      rot_right_d = dir_s;
      load_data_d = data_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= REL_CHK;
      cnt_q       <= '0;
      step_q      <= 1'b0;
      par_load_q  <= 1'b0;
      rot_right_q <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      par_load_q  <= par_load_d;
      rot_right_q <= rot_right_d;
      load_data_q <= load_data_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.par_load  = par_load_q;
  assign bus.rot_right = rot_right_q;
  assign bus.load_data = load_data_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

`default_nettype wire
